// File: rtl/mul32_seq_ctrl_if.sv
// Start/busy/done handshake bundle for the sequential 32-bit multiplier.
// The controller takes the slave side; the requester drives the master side.
interface mul32_seq_ctrl_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// Shift-and-add multiplier controller: one shared ripple adder is stepped over
// 32 cycles to form the low 32 bits of a*b, with a start/busy/done handshake.

module add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic [31:0] w_carry;

  assign w_carry[0] = 1'b0;

  // Plain ripple chain; the carry out of bit 31 is dropped (modulo 2^32)
  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    if (gi < 31) begin : g_carry
      assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  end
endmodule

module mul32_seq_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  mul32_seq_ctrl_if.slave      bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_count;
  logic [31:0] r_product;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_sum;
  logic [31:0] w_acc_next;
  logic        w_last;

  add32 u_add32 (
    .i_a   (r_acc),
    .i_b   (r_mcand),
    .o_sum (w_sum)
  );

  // Partial-product select for the current RUN step
  always_comb begin
    w_acc_next = r_acc;
    w_last     = 1'b0;
    if (r_mplier[0]) begin
      w_acc_next = w_sum;
    end else begin
      w_acc_next = r_acc;
    end
    if (r_count == 5'd31) begin
      w_last = 1'b1;
    end else begin
      w_last = 1'b0;
    end
  end

  // Sequencer and datapath registers; busy/done are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mcand   <= 32'd0;
      r_mplier  <= 32'd0;
      r_acc     <= 32'd0;
      r_count   <= 5'd0;
      r_product <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= 32'd0;
            r_count  <= 5'd0;
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_count  <= r_count + 5'd1;
          r_busy   <= 1'b1;
          // Fixed 32 steps: no early exit even once the multiplier runs out of ones
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
          end else begin
            r_done    <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Scoreboard bench for mul32_seq_ctrl: stimulus pushes (a*b) mod 2^32 and the
// accept cycle; a monitor checks product and 32-edge latency on every done.
module tb_mul32_seq_ctrl;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] last_prod;

  mul32_seq_ctrl_if bus();

  mul32_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on every done pulse, otherwise the held product must not move
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        chk("done_implies_busy", 32'(bus.busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          int          t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          chk("product", bus.product, e);
          chk("latency", 32'(cyc - t), 32'd32);
          last_prod = e;
        end
      end else begin
        chk("product_held", bus.product, last_prod);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [31:0] p;
    n = 0;
    while (bus.busy && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) chk("timeout_idle", 32'd1, 32'd0);
    p = x * y;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    exp_q.push_back(p);
    acc_q.push_back(cyc + 1);
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) chk("timeout_drain", 32'd1, 32'd0);
  endtask

  initial begin
    int c0;
    int n;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    last_prod = 32'd0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;

    step(3);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", bus.product, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Basic and edge operands
    do_op(32'd6, 32'd7);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    drain();
    step(3);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    do_op(32'h0001_0000, 32'h0001_0000); drain();
    do_op(32'd0, 32'h1234_5678);         drain();
    do_op(32'hFFFF_FFFD, 32'd5);         drain();

    // Reset mid-operation discards the result
    do_op(32'd7, 32'd9);
    step(9);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(bus.busy), 32'd0);
    chk("midrun_reset_done", 32'(bus.done), 32'd0);
    chk("midrun_reset_product", bus.product, 32'd0);
    exp_q.delete();
    acc_q.delete();
    last_prod = 32'd0;
    step(2);
    rst_n = 1'b1;
    step(40);

    // start ignored during RUN and during DONE
    do_op(32'd100, 32'd200);
    step(4);
    bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout_done", 32'd1, 32'd0);
    bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(40);
    chk("ignored_start_queue", 32'(exp_q.size()), 32'd0);

    // start held high: back-to-back operations with a single idle cycle
    c0 = cyc + 1;
    bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'd12);
      acc_q.push_back(c0 + 34 * k);
    end
    while (cyc != c0 + 33) @(negedge clk);
    chk("gap_busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("gap_busy_high", 32'(bus.busy), 32'd1);
    while (cyc < c0 + 68) step(1);
    bus.start = 1'b0;
    drain();

    // Random operand pairs
    for (int i = 0; i < 1000; i++) begin
      do_op($urandom, $urandom);
    end
    drain();
    step(5);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
